seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for one shared seg7_decoder (4511-style: LE, BL#, LT#, D[3:0]).

---
 rtl/seg7_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Scan controller that time-multiplexes a DIGITS-wide BCD frame onto one shared 4511-style decoder.
// Build macro LEADING_ZERO_BLANK_EN blanks, during SHOW, every digit above the highest nonzero digit.
module seg7_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                lamp_test,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data_in,
  output logic [3:0]          D,
  output logic                LE,
  output logic                BL,
  output logic                LT,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_done,
  output logic [1:0]          state_dbg
);
  localparam int CMAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                pending_q, pending_d;
  logic [3:0]          d_q, d_d;
  logic                le_q, le_d;
  logic                bl_q, bl_d;
  logic                lt_q, lt_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                fd_q, fd_d;
  logic                wrap;
  logic                lz_blank;
  logic [3:0]          digit;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    fd_d      = 1'b0;
    wrap      = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            fd_d  = 1'b1;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The displayed frame only changes at a frame boundary (or while idle), so a frame never mixes loads.
    if (load && (state_q == IDLE || wrap)) begin
      disp_d    = data_in;
      shadow_d  = data_in;
      pending_d = 1'b0;
    end else if (wrap && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] top_nz;
  always_comb begin
    top_nz = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (disp_d[4*i +: 4] != 4'd0) top_nz = IW'(i);
    end
  end
  assign lz_blank = (idx_d > top_nz);
`else
  assign lz_blank = 1'b0;
`endif

  // Outputs are computed from the next state so they change on the same edge as the state.
  always_comb begin
    digit = 4'(disp_d >> {idx_d, 2'b00});
    d_d   = 4'd0;
    le_d  = 1'b1;
    bl_d  = 1'b0;
    sel_d = '0;
    lt_d  = ~lamp_test;
    case (state_d)
      BLANK: begin
        d_d  = digit;
        le_d = 1'b0;
      end
      SHOW: begin
        d_d   = digit;
        le_d  = 1'b0;
        bl_d  = ~lz_blank;
        sel_d = DIGITS'(1) << idx_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      d_q       <= 4'd0;
      le_q      <= 1'b1;
      bl_q      <= 1'b0;
      lt_q      <= 1'b1;
      sel_q     <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      d_q       <= d_d;
      le_q      <= le_d;
      bl_q      <= bl_d;
      lt_q      <= lt_d;
      sel_q     <= sel_d;
      fd_q      <= fd_d;
    end
  end

  assign D          = d_q;
  assign LE         = le_q;
  assign BL         = bl_q;
  assign LT         = lt_q;
  assign dig_sel    = sel_q;
  assign frame_done = fd_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a frame-time model (run flag + position in frame) predicts every output each cycle,
// directed scenarios pin the model with literal values, then a randomized phase exercises en/load/lamp_test/rst.
module tb_seg7_scan_ctrl;
  localparam int DIGITS    = 4;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = BLANK_CYC + DIV;
  localparam int FRAME     = DIGITS * SLOT;
  localparam int W         = 4 + 3 + DIGITS + 1;
  localparam int BOUND     = 200;

  logic                clk = 1'b0;
  logic                rst, en, lamp_test, load;
  logic [4*DIGITS-1:0] data_in;
  logic [3:0]          D;
  logic                LE, BL, LT, frame_done;
  logic [DIGITS-1:0]   dig_sel;
  logic [1:0]          state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int fd_seen;

  logic [W-1:0] exp_q[$];

  bit                  m_run = 1'b0;
  int                  m_t = 0;
  logic [4*DIGITS-1:0] m_disp = '0;
  logic [4*DIGITS-1:0] m_shadow = '0;
  bit                  m_pending = 1'b0;
  bit                  m_fd = 1'b0;
  bit                  m_lt = 1'b1;

  seg7_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst(rst), .en(en), .lamp_test(lamp_test), .load(load), .data_in(data_in),
    .D(D), .LE(LE), .BL(BL), .LT(LT), .dig_sel(dig_sel), .frame_done(frame_done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic bit lz_suppressed(input int dig);
`ifdef LEADING_ZERO_BLANK_EN
    int top = 0;
    for (int i = 1; i < DIGITS; i++)
      if (((m_disp >> (4*i)) & 'hF) != 0) top = i;
    return dig > top;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [3:0]        d;
    logic              le, bl;
    logic [DIGITS-1:0] sel;
    int                pos, dig;
    if (!m_run) begin
      d = 4'd0; le = 1'b1; bl = 1'b0; sel = '0;
    end else begin
      pos = m_t % SLOT;
      dig = (m_t / SLOT) % DIGITS;
      d   = 4'(m_disp >> (4*dig));
      le  = 1'b0;
      if (pos < BLANK_CYC) begin
        bl = 1'b0; sel = '0;
      end else begin
        bl = !lz_suppressed(dig); sel = DIGITS'(1) << dig;
      end
    end
    return {d, le, bl, m_lt, sel, m_fd};
  endfunction

  // reference model: advances one clock per rising edge
  always @(posedge clk) begin
    m_fd = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_disp = '0; m_shadow = '0; m_pending = 1'b0; m_lt = 1'b1;
    end else begin
      m_lt = !lamp_test;
      if (!m_run) begin
        if (load) begin m_disp = data_in; m_shadow = data_in; m_pending = 1'b0; end
        if (en) begin m_run = 1'b1; m_t = 0; end
      end else if (!en) begin
        m_run = 1'b0; m_t = 0;
        if (load) begin m_shadow = data_in; m_pending = 1'b1; end
      end else begin
        m_t = (m_t + 1) % FRAME;
        if (m_t == 0) begin
          m_fd = 1'b1;
          if (load) begin m_disp = data_in; m_shadow = data_in; end
          else if (m_pending) m_disp = m_shadow;
          m_pending = 1'b0;
        end else if (load) begin
          m_shadow = data_in; m_pending = 1'b1;
        end
      end
    end
    exp_q.push_back(model_out());
  end

  // scoreboard compare
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("outputs", 32'({D, LE, BL, LT, dig_sel, frame_done}), 32'(e));
    end
  end

  task automatic wait_t(input int tt, input string nm);
    int n = 0;
    while (!(m_run && m_t == tt) && n < BOUND) begin
      step();
      n++;
    end
    chk({nm, "_reached"}, 32'(n < BOUND), 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; lamp_test = 1'b0; load = 1'b0; data_in = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_LE", LE, 1); chk("rst_BL", BL, 0); chk("rst_LT", LT, 1);
    chk("rst_sel", dig_sel, 0); chk("rst_D", D, 0);

    fd_seen = 0;
    repeat (20) begin step(); if (frame_done) fd_seen++; end
    chk("idle_no_frame_done", fd_seen, 0);
    chk("idle_LE", LE, 1);

    load = 1'b1; data_in = 16'h4321; step();
    load = 1'b0; en = 1'b1;
    step();
    chk("blank0_sel", dig_sel, 0); chk("blank0_BL", BL, 0); chk("blank0_D", D, 1);
    repeat (2) step();
    chk("show0_D", D, 1); chk("show0_sel", dig_sel, 4'b0001); chk("show0_BL", BL, 1);
    repeat (6) step();
    chk("show1_D", D, 2); chk("show1_sel", dig_sel, 4'b0010);
    repeat (6) step();
    chk("show2_D", D, 3); chk("show2_sel", dig_sel, 4'b0100);
    repeat (6) step();
    chk("show3_D", D, 4); chk("show3_sel", dig_sel, 4'b1000);
    repeat (3) step();
    chk("fd_before_wrap", frame_done, 0);
    step();
    chk("fd_wrap1", frame_done, 1);
    repeat (23) step();
    chk("fd_gap", frame_done, 0);
    step();
    chk("fd_wrap2", frame_done, 1);

    repeat (8) step();
    load = 1'b1; data_in = 16'h9876; step();
    load = 1'b0;
    repeat (5) step();
    chk("midload_old_frame", D, 3);
    repeat (12) step();
    chk("midload_new_frame", D, 6);

    wait_t(FRAME - 1, "wrap_load");
    load = 1'b1; data_in = 16'h1234; step();
    load = 1'b0;
    chk("wrap_load_fd", frame_done, 1);
    chk("wrap_load_D", D, 4);

    wait_t(BLANK_CYC + 1, "lamp");
    lamp_test = 1'b1; step();
    chk("lamp_LT", LT, 0); chk("lamp_sel", dig_sel, 4'b0001);
    repeat (2) step();
    chk("lamp_blank_BL", BL, 0); chk("lamp_blank_sel", dig_sel, 0);
    lamp_test = 1'b0; step();
    chk("lamp_off_LT", LT, 1);

    wait_t(SLOT + BLANK_CYC + 1, "en_drop");
    en = 1'b0; step();
    chk("en_drop_BL", BL, 0); chk("en_drop_sel", dig_sel, 0); chk("en_drop_LE", LE, 1);
    repeat (3) step();
    en = 1'b1;
    repeat (3) step();
    chk("reen_sel", dig_sel, 4'b0001); chk("reen_D", D, 4);

    en = 1'b0; step();
    load = 1'b1; data_in = 16'h0050; step();
    load = 1'b0; en = 1'b1;
    repeat (SLOT + BLANK_CYC + 1) step();
    chk("lz_d1_D", D, 5); chk("lz_d1_BL", BL, 1);
    repeat (2 * SLOT) step();
    chk("lz_d3_D", D, 0); chk("lz_d3_sel", dig_sel, 4'b1000);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d3_BL", BL, 0);
`else
    chk("lz_d3_BL", BL, 1);
`endif

    wait_t(2 * SLOT + BLANK_CYC, "rst_mid");
    rst = 1'b1; step();
    chk("rstmid_D", D, 0); chk("rstmid_LE", LE, 1); chk("rstmid_BL", BL, 0);
    chk("rstmid_sel", dig_sel, 0); chk("rstmid_fd", frame_done, 0);
    rst = 1'b0;
    repeat (SLOT + BLANK_CYC + 1) step();
    chk("rstmid_disp_cleared", D, 0); chk("rstmid_restart_sel", dig_sel, 4'b0010);

    load = 1'b1; data_in = 16'h0000; step();
    load = 1'b0;
    repeat (2 * FRAME) step();

    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 99) < 97);
      load    = ($urandom_range(0, 15) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(0, 39) == 0) lamp_test = !lamp_test;
      rst     = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0; en = 1'b1; lamp_test = 1'b0;
    repeat (FRAME) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
